// File: rtl/tpm_axil_pkg.sv
// Shared types, AXI response codes and address helper for the TPM AXI4-Lite master engine.
// Purely declarative: no logic, no latency.
// No flow control of its own.
package tpm_axil_pkg;

    typedef enum logic [1:0] {
        MODE_WR     = 2'd0,
        MODE_RD     = 2'd1,
        MODE_VERIFY = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Byte address of beat idx; callers truncate to their address width, so overflow wraps.
    function automatic logic [63:0] beat_addr(input logic [63:0] base,
                                              input logic [8:0]  idx,
                                              input logic [3:0]  nbytes);
        return base + (64'(idx) * 64'(nbytes));
    endfunction

endpackage

// File: rtl/tpm_axil_mst_engine_edge.sv
// Registered rising-edge detector for the engine start request.
// Latency: pulse is high for one cycle, one cycle after din is first sampled high.
// No backpressure: every 0->1 transition produces exactly one pulse.
module tpm_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic d_q;
    logic d_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q  <= 1'b0;
            d_qq <= 1'b0;
        end else begin
            d_q  <= din;
            d_qq <= d_q;
        end
    end

    assign pulse = d_q & ~d_qq;

endmodule

// File: rtl/tpm_axil_mst_engine.sv
// AXI4-Lite master traffic engine: NUM_TXN writes, reads or write+readback per start; optional RUN_CYCLES via TPM_AXIL_MST_PERF_EN.
// Latency: first AWVALID 2 cycles after the INIT edge; each beat takes 3 cycles against a zero-wait slave.
// Backpressure: VALIDs hold until their handshake; one beat outstanding at a time; BREADY/RREADY only after the request is accepted.
module tpm_axil_mst_engine
    import tpm_axil_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_TXN = 4,
    parameter int CNT_W   = $clog2(NUM_TXN + 1)
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                INIT_AXI_TXN,
    input  logic [1:0]          MODE,
    input  logic [ADDR_W-1:0]   BASE_ADDR,
    input  logic [DATA_W-1:0]   SEED,
    output logic                TXN_DONE,
    output logic                ERROR,
`ifdef TPM_AXIL_MST_PERF_EN
    output logic [31:0]         RUN_CYCLES,
`endif
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [2:0]          M_AXI_ARPROT,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    state_e              state_q, state_d;
    mode_e               mode_q;
    logic [ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]   seed_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                pend_q, aw_done_q, w_done_q, ar_done_q;
    logic                awvalid_q, wvalid_q, arvalid_q, error_q;
    logic                start_pulse, start_acc, last_beat, rd_bad;
    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_data;

    tpm_edge_detect u_start_edge (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .din   (INIT_AXI_TXN),
        .pulse (start_pulse)
    );

    assign start_acc = start_pulse & ((state_q == IDLE) | (state_q == DONE));
    assign cur_addr  = ADDR_W'(beat_addr(64'(base_q), 9'(cnt_q), 4'(DATA_W / 8)));
    assign cur_data  = seed_q + DATA_W'(cnt_q);
    assign last_beat = (cnt_q == CNT_W'(NUM_TXN - 1));

    assign M_AXI_BREADY = (state_q == WR) & pend_q & aw_done_q & w_done_q;
    assign M_AXI_RREADY = (state_q == RD) & pend_q & ar_done_q;

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q & M_AXI_WREADY;
    assign b_hs  = M_AXI_BREADY & M_AXI_BVALID;
    assign ar_hs = arvalid_q & M_AXI_ARREADY;
    assign r_hs  = M_AXI_RREADY & M_AXI_RVALID;

    // Mode 1 never compares data; the readback pass of mode 2 checks against the seed sequence.
    assign rd_bad = (M_AXI_RRESP != OKAY) ||
                    ((mode_q == MODE_VERIFY) && (M_AXI_RDATA != cur_data));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_acc) state_d = (MODE == 2'd1) ? RD : WR;
            WR:         if (b_hs && last_beat) state_d = (mode_q == MODE_WR) ? DONE : RD;
            RD:         if (r_hs && last_beat) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            mode_q    <= MODE_WR;
            base_q    <= '0;
            seed_q    <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            error_q   <= 1'b0;
        end else if (start_acc) begin
            mode_q    <= (MODE == 2'd3) ? MODE_VERIFY : mode_e'(MODE);
            base_q    <= BASE_ADDR;
            seed_q    <= SEED;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                WR: begin
                    // pend_q low means a beat slot is free: launch AW and W together.
                    if (!pend_q) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        pend_q    <= 1'b1;
                    end
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (b_hs) begin
                        pend_q    <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        cnt_q     <= last_beat ? '0 : cnt_q + CNT_W'(1);
                        if (M_AXI_BRESP != OKAY) error_q <= 1'b1;
                    end
                end
                RD: begin
                    if (!pend_q) begin
                        arvalid_q <= 1'b1;
                        pend_q    <= 1'b1;
                    end
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        ar_done_q <= 1'b1;
                    end
                    if (r_hs) begin
                        pend_q    <= 1'b0;
                        ar_done_q <= 1'b0;
                        cnt_q     <= last_beat ? '0 : cnt_q + CNT_W'(1);
                        if (rd_bad) error_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TPM_AXIL_MST_PERF_EN
    logic [31:0] run_cycles_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run_cycles_q <= '0;
        end else if (start_acc) begin
            run_cycles_q <= '0;
        end else if (((state_q == WR) || (state_q == RD)) && (run_cycles_q != '1)) begin
            run_cycles_q <= run_cycles_q + 32'd1;
        end
    end

    assign RUN_CYCLES = run_cycles_q;
`endif

    assign TXN_DONE      = (state_q == DONE);
    assign ERROR         = error_q;
    assign M_AXI_AWADDR  = cur_addr;
    assign M_AXI_ARADDR  = cur_addr;
    assign M_AXI_WDATA   = cur_data;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_ARVALID = arvalid_q;

endmodule

// File: doc/tpm_axil_mst_engine.md
Name: tpm_axil_mst_engine

Overview:
- Parametrised AXI4-Lite master traffic engine; successor to the fixed TPM_TO_MAIN / TPM_TO_PRIV master test engines.
- One engine is instantiated per outbound TPM port.
- A start pulse runs NUM_TXN transfers from a runtime base address in a runtime-selected mode: write-only, read-only, or write-then-readback verify.
- Reports a done level and a sticky error.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; 32 or 64 only.
- NUM_TXN, 4, transfers per run; must be 1..256.
- CNT_W, $clog2(NUM_TXN+1), width of the transfer counter.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- INIT_AXI_TXN  in  1  start request; rising edge detected internally.
- MODE  in  2  0=write-only, 1=read-only, 2=write+verify, 3=reserved (treated as 2); sampled at start.
- BASE_ADDR  in  ADDR_W  first transfer address; sampled at start.
- SEED  in  DATA_W  data for transfer 0; sampled at start.
- TXN_DONE  out  1  high from run completion until the next accepted start.
- ERROR  out  1  sticky; cleared on the next accepted start.
- M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR_W/3/1; M_AXI_AWREADY in 1.
- M_AXI_WDATA/WSTRB/WVALID  out  DATA_W/DATA_W/8/1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2, M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR_W/3/1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in DATA_W, M_AXI_RRESP in 2, M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Reset: all VALID/READY outputs 0, TXN_DONE 0, ERROR 0, state IDLE, counters 0. Reset takes effect immediately, including mid-transfer.
- Start: a 0->1 edge of INIT_AXI_TXN, registered, is accepted only in IDLE or DONE. Edges seen in any other state are ignored.
- On accepted start: latch MODE, BASE_ADDR and SEED; clear ERROR and TXN_DONE; go to WR (modes 0 and 2) or RD (mode 1).
- Transfer i uses address BASE_ADDR + i*(DATA_W/8), computed modulo 2^ADDR_W (wraps silently). Data is SEED + i modulo 2^DATA_W.
- AxPROT is 0 and WSTRB is all ones.
- WR: AWVALID and WVALID assert together, the cycle after entering WR. Each drops independently on its own handshake.
- WR response: BREADY asserts once both AW and W have handshaken. On the B handshake, BRESP != OKAY sets ERROR; then i++.
- After the last write: mode 0 goes to DONE; mode 2 resets i to 0 and goes to RD.
- RD: ARVALID asserts and drops on ARREADY; RREADY then asserts until the R handshake. At most one read is outstanding.
- Read check: RRESP != OKAY sets ERROR. In mode 2, RDATA != SEED + i also sets ERROR; mode 1 does not compare data.
- After the last read: go to DONE.
- DONE: TXN_DONE=1, ERROR holds. The engine stays in DONE until the next accepted start.
- A VALID, once asserted, never deasserts before its handshake. Write address/data never depend on READY.
- Simultaneous AW and W handshakes in the same cycle are legal. An early BVALID (before both AW and W handshakes) is not accepted.
- Latency, zero-wait slave: the first AWVALID appears 2 cycles after the INIT edge. Each write takes 3 cycles and each read 3 cycles.

Optional Feature:
- Macro: TPM_AXIL_MST_PERF_EN.
- Defined: adds output RUN_CYCLES [31:0]. It is cleared on an accepted start, increments every cycle outside IDLE/DONE, saturates at 0xFFFFFFFF, and holds in DONE.
- Undefined: no port, no counter logic.

Decomposition:
- Package tpm_axil_pkg holds:
  - mode_e enum;
  - state_e (IDLE, WR, RD, DONE);
  - AXI resp constants OKAY/EXOKAY/SLVERR/DECERR;
  - function beat_addr(base, i).
- One sub-module, tpm_edge_detect: registered rising-edge pulse on INIT_AXI_TXN, async active-low reset.

Test Plan:
- Mode 2, BASE=0x0, SEED=0x1, NUM_TXN=4, zero-wait memory slave -> writes 1..4 to 0x0/0x4/0x8/0xC; readback matches; TXN_DONE=1, ERROR=0; first AWVALID 2 cycles after the INIT edge.
- Mode 2, slave returns SLVERR on the 3rd B -> run completes all 4 writes and 4 reads; ERROR=1 sticky; the next INIT clears it.
- Mode 2, slave corrupts read data word 1 (0x2 -> 0x3) -> ERROR=1; mode 1 with the same slave -> ERROR=0.
- Randomised AWREADY/WREADY/ARREADY/RVALID stalls (0-7 cycles), AWREADY arriving 5 cycles after WREADY -> no VALID drops early; BREADY only after both handshakes.
- BASE=0xFFFFFFF8, DATA_W=32, mode 0 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; INIT pulse mid-run ignored.
- ARESETN low during the 2nd write with AWVALID high -> all VALID/READY 0 and TXN_DONE 0 immediately; after release, INIT runs cleanly. With TPM_AXIL_MST_PERF_EN, zero-wait mode 2 gives RUN_CYCLES=24.
